vx_stream_lru_arbiter: RTL and testbench
========================================

# vx_stream_lru_arbiter

Shares one valid/ready output stream among `NUM_REQS` input streams. Selection is least-recently-granted, kept in a triangular priority matrix. An optional packet lock holds the grant until the winning stream's `last` beat, and an optional skid-buffer output stage breaks the `ready` path. It sits in front of shared resources such as memory ports, the writeback bus and the dispatch crossbar, where a bare combinational arbiter has no handshake or flow control.

## Interface
- `NUM_REQS`, 4: number of input streams, ≥1.
- `DATAW`, 32: payload width.
- `PACKET_LOCK`, 0: 1 holds the grant from the first accepted beat through the accepted `last` beat.
- `OUT_REG`, 1: 1 registers the output through a 2-entry skid buffer; 0 is a combinational pass-through.
- `LOG_NUM_REQS`, `$clog2(NUM_REQS)`, minimum 1: width of `sel_out`.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset (asserted when 0).
- `valid_in`  in  NUM_REQS  per-stream valid.
- `data_in`  in  NUM_REQS*DATAW  per-stream payload; stream i occupies bits [i*DATAW +: DATAW].
- `last_in`  in  NUM_REQS  end-of-packet marker; ignored when PACKET_LOCK=0.
- `ready_in`  out  NUM_REQS  per-stream accept.
- `valid_out`  out  1  output valid.
- `data_out`  out  DATAW  granted payload.
- `last_out`  out  1  granted `last`.
- `sel_out`  out  LOG_NUM_REQS  index of the source stream for the current output beat.
- `ready_out`  in  1  downstream accept.

## Operation
- **Priority matrix.** `prio[i][j]` for i<j, 1 = i beats j; the lower triangle is the implied complement.
  - Reset value: all 1, so the lowest index has the highest priority.
  - Requester i wins when it is valid and no other valid j beats it.
- **Matrix update.** Only on an accepted input beat (`valid_in[g] && ready_in[g]`), and with PACKET_LOCK=1 only on the accepted `last` beat.
  - g loses to every other stream.
  - All other pairs are unchanged.
  - No update without a handshake, so stalls never rotate priority.
- **Packet lock (PACKET_LOCK=1).**
  - States: IDLE and LOCKED(idx).
  - IDLE → LOCKED(g) on an accepted beat with `last_in[g]`=0.
  - LOCKED(idx) → IDLE on an accepted beat with `last_in[idx]`=1.
  - While LOCKED, only idx can be granted, even when idx is not valid; other streams wait.
  - A single-beat packet (`last`=1 on the first beat) never leaves IDLE.
- **Accept path.**
  - `ready_in[g]` = output-side ready (`ready_out` when OUT_REG=0, buffer-not-full when OUT_REG=1) AND g is the current winner.
  - At most one `ready_in` bit is high per cycle.
- **NUM_REQS=1.** No matrix and no lock state; the block reduces to stream 0 passed through, registered when OUT_REG=1. `sel_out` is always 0.
- **Reset** (`reset`=0 on a clock edge):
  - Matrix returns to its reset value; lock returns to IDLE.
  - Skid buffer is emptied.
  - `valid_out`=0, `last_out`=0, `data_out`=0, `sel_out`=0.
  - `ready_in`=0 on every cycle `reset` is low.
  - A reset in the middle of a packet drops the lock and any buffered beats; no partial beat appears after release.

## Timing
- **OUT_REG=0.** Zero latency. `valid_out`, `data_out`, `last_out` and `sel_out` are combinational from the inputs and the state; `ready_in` depends combinationally on `ready_out`.
- **OUT_REG=1.**
  - A beat accepted in cycle t is visible on the output in cycle t+1.
  - Full throughput: 1 beat per cycle while `ready_out`=1.
  - `ready_in` depends only on registered buffer occupancy, with no combinational path from `ready_out`.
  - The buffer accepts while it holds fewer than 2 entries.
  - When `ready_out` drops, at most one extra beat is absorbed.
  - Output order equals acceptance order.
- **Output hold.** While `valid_out`=1 and `ready_out`=0, `data_out`, `last_out` and `sel_out` hold steady.
- **Grant timing.** The grant decision uses the matrix and lock state as of the start of the cycle. The update takes effect on the next cycle.

## Structure
- The shared package `VX_gpu_pkg` gets no new typedefs. The block is parameter-local; `LOG_NUM_REQS` is a localparam-style derived parameter.
- Sub-module `vx_stream_skid_buffer` (DATAW+1+LOG_NUM_REQS wide): the 2-entry skid buffer, instantiated when OUT_REG=1.
- Matrix, lock FSM and onehot-to-index encoding stay inline in the top module.

## Test plan
- **Reset and idle.** `reset`=0 for 3 cycles, with `valid_in`=4'b1111 during reset. Required: `ready_in`=0 and `valid_out`=0 in every reset cycle. After release, the first accepted beat comes from stream 0.
- **LRU rotation.** NUM_REQS=4, all streams valid continuously, `ready_out`=1. Required: `sel_out` sequence 0,1,2,3,0,1 (OUT_REG=1: first beat at cycle 1 after release).
- **Stall keeps priority.** Streams 1 and 2 valid, `ready_out`=0 for 5 cycles, then 1. Required: the first output is stream 1. The buffer fills to 2 and then `ready_in`=0. No matrix change during the stall.
- **Packet lock.** PACKET_LOCK=1. Stream 2 sends 3 beats (`last` on beat 3) while stream 0 is valid throughout. Required: `sel_out`=2,2,2, then 0. `ready_in[0]`=0 until stream 2's last beat is accepted.
- **Lock gap.** PACKET_LOCK=1. Stream 1 drops `valid` for 2 cycles mid-packet while stream 3 is valid. Required: stream 3 is not granted during the gap, and stream 1 resumes.
- **Reset mid-packet.** Reset asserted during a locked 4-beat packet. Required: the outputs clear, no leftover beats appear, and after release stream 0 wins with the lock in IDLE.

Source files
------------

// File: rtl/vx_stream_lru_arbiter_pkg.sv
// Shared types and sizing helpers for the LRU stream arbiter.
package vx_stream_lru_arbiter_pkg;

    typedef enum logic {LockIdle, LockHeld} lock_state_e;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned tri_size(input int unsigned n);
        return (n > 1) ? (n * (n - 1)) / 2 : 1;
    endfunction

    // Flat position of upper-triangle pair (i, j), i < j, in an n-by-n matrix.
    function automatic int unsigned tri_idx(input int unsigned i, input int unsigned j,
                                            input int unsigned n);
        return i * n - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

endpackage

// File: rtl/vx_stream_skid_buffer.sv
// Two-entry skid buffer; input ready depends only on registered occupancy.
module vx_stream_skid_buffer #(
    parameter int unsigned DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [DATAW-1:0] data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [DATAW-1:0] data_out,
    input  logic             ready_out
);

    logic [1:0]       count_q;
    logic [DATAW-1:0] head_q;
    logic [DATAW-1:0] tail_q;
    logic             push;
    logic             pop;

    assign ready_in  = (count_q != 2'd2);
    assign valid_out = (count_q != 2'd0);
    assign data_out  = head_q;
    assign push      = valid_in && ready_in;
    assign pop       = valid_out && ready_out;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            if (push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop))) begin
                head_q <= data_in;
            end else if (pop) begin
                head_q <= tail_q;
            end
            if (push && (count_q == 2'd1) && !pop) begin
                tail_q <= data_in;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/vx_stream_lru_arbiter.sv
// Least-recently-granted valid/ready stream arbiter with optional packet lock
// and optional skid-buffered output.
module vx_stream_lru_arbiter
    import vx_stream_lru_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQS     = 4,
    parameter int unsigned DATAW        = 32,
    parameter bit          PACKET_LOCK  = 0,
    parameter bit          OUT_REG      = 1,
    parameter int unsigned LOG_NUM_REQS = idx_width(NUM_REQS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQS-1:0]          valid_in,
    input  logic [NUM_REQS*DATAW-1:0]    data_in,
    input  logic [NUM_REQS-1:0]          last_in,
    output logic [NUM_REQS-1:0]          ready_in,
    output logic                         valid_out,
    output logic [DATAW-1:0]             data_out,
    output logic                         last_out,
    output logic [LOG_NUM_REQS-1:0]      sel_out,
    input  logic                         ready_out
);

    logic [NUM_REQS-1:0]     grant;
    logic [LOG_NUM_REQS-1:0] grant_idx;
    logic [DATAW-1:0]        grant_data;
    logic                    grant_last;
    logic                    out_ready;
    logic                    fire;

    assign ready_in = grant & {NUM_REQS{out_ready & reset}};
    assign fire     = |ready_in;

    always_comb begin
        grant_data = '0;
        grant_last = 1'b0;
        grant_idx  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                grant_data = data_in[i*DATAW +: DATAW];
                grant_last = last_in[i];
                grant_idx  = LOG_NUM_REQS'(i);
            end
        end
    end

    if (NUM_REQS == 1) begin : g_single
        assign grant = valid_in;
    end else begin : g_multi
        localparam int unsigned TRI = tri_size(NUM_REQS);

        // prio_q[tri_idx(i, j)] = 1 means i beats j (i < j).
        logic [TRI-1:0]          prio_q;
        logic                    locked;
        logic [LOG_NUM_REQS-1:0] lock_idx;
        logic                    update;

        always_comb begin
            grant = '0;
            for (int i = 0; i < NUM_REQS; i++) begin
                if (locked) begin
                    grant[i] = valid_in[i] && (lock_idx == LOG_NUM_REQS'(i));
                end else begin
                    grant[i] = valid_in[i];
                    for (int j = 0; j < NUM_REQS; j++) begin
                        if (j < i && valid_in[j] && prio_q[tri_idx(j, i, NUM_REQS)]) begin
                            grant[i] = 1'b0;
                        end
                        if (j > i && valid_in[j] && !prio_q[tri_idx(i, j, NUM_REQS)]) begin
                            grant[i] = 1'b0;
                        end
                    end
                end
            end
        end

        assign update = fire && (!PACKET_LOCK || grant_last);

        always_ff @(posedge clk) begin
            if (!reset) begin
                prio_q <= '1;
            end else if (update) begin
                for (int i = 0; i < NUM_REQS; i++) begin
                    for (int j = i + 1; j < NUM_REQS; j++) begin
                        if (grant[i]) begin
                            prio_q[tri_idx(i, j, NUM_REQS)] <= 1'b0;
                        end else if (grant[j]) begin
                            prio_q[tri_idx(i, j, NUM_REQS)] <= 1'b1;
                        end
                    end
                end
            end
        end

        if (PACKET_LOCK) begin : g_lock
            lock_state_e             lock_q;
            logic [LOG_NUM_REQS-1:0] lock_idx_q;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    lock_q     <= LockIdle;
                    lock_idx_q <= '0;
                end else begin
                    unique case (lock_q)
                        LockIdle: begin
                            if (fire && !grant_last) begin
                                lock_q     <= LockHeld;
                                lock_idx_q <= grant_idx;
                            end
                        end
                        LockHeld: begin
                            if (fire && grant_last) begin
                                lock_q <= LockIdle;
                            end
                        end
                    endcase
                end
            end

            assign locked   = (lock_q == LockHeld);
            assign lock_idx = lock_idx_q;
        end else begin : g_nolock
            assign locked   = 1'b0;
            assign lock_idx = '0;
        end
    end

    if (OUT_REG) begin : g_out_reg
        localparam int unsigned BUFW = DATAW + 1 + LOG_NUM_REQS;

        logic [BUFW-1:0] buf_out;

        vx_stream_skid_buffer #(
            .DATAW(BUFW)
        ) u_skid (
            .clk      (clk),
            .reset    (reset),
            .valid_in (fire),
            .data_in  ({grant_data, grant_last, grant_idx}),
            .ready_in (out_ready),
            .valid_out(valid_out),
            .data_out (buf_out),
            .ready_out(ready_out)
        );

        assign {data_out, last_out, sel_out} = buf_out;
    end else begin : g_out_comb
        assign out_ready = ready_out;
        assign valid_out = (|grant) && reset;
        assign data_out  = reset ? grant_data : '0;
        assign last_out  = grant_last && reset;
        assign sel_out   = reset ? grant_idx : '0;
    end

endmodule

// File: tb/tb_vx_stream_lru_arbiter.sv
// Bench for vx_stream_lru_arbiter: hand-written vector table plus randomized
// traffic against an ordered-list LRU model, with and without packet lock.
module tb_vx_stream_lru_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   valid_in;
    logic [3:0]   last_in;
    logic [127:0] data_in;
    logic         ready_out;

    logic [3:0]  ri   [2];
    logic        vo   [2];
    logic [31:0] dout [2];
    logic        lout [2];
    logic [1:0]  sout [2];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vx_stream_lru_arbiter #(
        .NUM_REQS(4), .DATAW(32), .PACKET_LOCK(0), .OUT_REG(1)
    ) dut0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .last_in(last_in), .ready_in(ri[0]), .valid_out(vo[0]), .data_out(dout[0]),
        .last_out(lout[0]), .sel_out(sout[0]), .ready_out(ready_out)
    );

    vx_stream_lru_arbiter #(
        .NUM_REQS(4), .DATAW(32), .PACKET_LOCK(1), .OUT_REG(1)
    ) dut1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .last_in(last_in), .ready_in(ri[1]), .valid_out(vo[1]), .data_out(dout[1]),
        .last_out(lout[1]), .sel_out(sout[1]), .ready_out(ready_out)
    );

    // Reference model: ord[d] lists streams from highest to lowest priority.
    int          ord   [2][4];
    bit          lk    [2];
    int          lidx  [2];
    int          cnt   [2];
    logic [31:0] bdata [2][2];
    logic        blast [2][2];
    int          bsel  [2][2];

    function automatic void model_reset(input int d);
        for (int k = 0; k < 4; k++) ord[d][k] = k;
        lk[d] = 0;
        lidx[d] = 0;
        cnt[d] = 0;
    endfunction

    function automatic int model_winner(input int d);
        if (d == 1 && lk[d]) return valid_in[lidx[d]] ? lidx[d] : -1;
        for (int k = 0; k < 4; k++) if (valid_in[ord[d][k]]) return ord[d][k];
        return -1;
    endfunction

    function automatic logic [3:0] model_ready(input int d);
        int w;
        logic [3:0] r;
        r = 4'b0000;
        w = model_winner(d);
        if (reset && w >= 0 && cnt[d] < 2) r[w] = 1'b1;
        return r;
    endfunction

    function automatic void move_back(input int d, input int w);
        int p;
        p = 0;
        for (int k = 0; k < 4; k++) if (ord[d][k] == w) p = k;
        for (int k = p; k < 3; k++) ord[d][k] = ord[d][k+1];
        ord[d][3] = w;
    endfunction

    function automatic void model_step(input int d);
        int w;
        bit acc;
        bit pop;
        if (!reset) begin
            model_reset(d);
            return;
        end
        w   = model_winner(d);
        acc = (w >= 0) && (cnt[d] < 2);
        pop = (cnt[d] > 0) && ready_out;
        if (pop) begin
            bdata[d][0] = bdata[d][1];
            blast[d][0] = blast[d][1];
            bsel[d][0]  = bsel[d][1];
            cnt[d]--;
        end
        if (acc) begin
            bdata[d][cnt[d]] = data_in[w*32 +: 32];
            blast[d][cnt[d]] = last_in[w];
            bsel[d][cnt[d]]  = w;
            cnt[d]++;
            if (d == 0 || last_in[w]) move_back(d, w);
            if (d == 1) begin
                if (!lk[d] && !last_in[w]) begin
                    lk[d] = 1;
                    lidx[d] = w;
                end else if (lk[d] && last_in[w]) begin
                    lk[d] = 0;
                end
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input logic [3:0] v, input logic [3:0] l, input bit rdy);
        @(negedge clk);
        reset     = rst;
        valid_in  = v;
        last_in   = l;
        ready_out = rdy;
        data_in   = {$urandom, $urandom, $urandom, $urandom};
        #1;
    endtask

    task automatic check_model();
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("model dut%0d ready_in", d), 64'(ri[d]), 64'(model_ready(d)));
            chk($sformatf("model dut%0d valid_out", d), 64'(vo[d]), 64'(cnt[d] > 0));
            if (cnt[d] > 0) begin
                chk($sformatf("model dut%0d data_out", d), 64'(dout[d]), 64'(bdata[d][0]));
                chk($sformatf("model dut%0d last_out", d), 64'(lout[d]), 64'(blast[d][0]));
                chk($sformatf("model dut%0d sel_out", d), 64'(sout[d]), 64'(bsel[d][0]));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
    endtask

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        logic [3:0] last;
        bit         rdy;
        logic [3:0] ri0;
        bit         vo0;
        int         sel0;
        logic [3:0] ri1;
        bit         vo1;
        int         sel1;
        bit         zero;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input bit rst, input logic [3:0] val, input logic [3:0] lst,
                              input bit rdy, input logic [3:0] ri0, input bit vo0, input int s0,
                              input logic [3:0] ri1, input bit vo1, input int s1, input bit z);
        vec_t r;
        r = '{rst, val, lst, rdy, ri0, vo0, s0, ri1, vo1, s1, z};
        vecs.push_back(r);
    endfunction

    initial begin
        reset = 1'b0;
        valid_in = '0;
        last_in = '0;
        data_in = '0;
        ready_out = 1'b0;
        model_reset(0);
        model_reset(1);
        @(posedge clk);

        // Reset with all streams requesting.
        for (int k = 0; k < 3; k++) v(0, 4'b1111, 4'b1111, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
        // LRU rotation, single-beat packets.
        v(1, 4'b1111, 4'b1111, 1, 4'b0001, 0, 0, 4'b0001, 0, 0, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 4'b0010, 1, 0, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 4'b0100, 1, 1, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b1000, 1, 2, 4'b1000, 1, 2, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b0001, 1, 3, 4'b0001, 1, 3, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b0010, 1, 0, 4'b0010, 1, 0, 0);
        v(1, 4'b1111, 4'b1111, 1, 4'b0100, 1, 1, 4'b0100, 1, 1, 0);
        v(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 4'b0000, 1, 2, 0);
        // Stall: buffer fills, priority frozen.
        v(1, 4'b0110, 4'b0110, 0, 4'b0010, 0, 0, 4'b0010, 0, 0, 0);
        v(1, 4'b0110, 4'b0110, 0, 4'b0100, 1, 1, 4'b0100, 1, 1, 0);
        for (int k = 0; k < 3; k++) v(1, 4'b0110, 4'b0110, 0, 4'b0000, 1, 1, 4'b0000, 1, 1, 0);
        v(1, 4'b0110, 4'b0110, 1, 4'b0000, 1, 1, 4'b0000, 1, 1, 0);
        v(1, 4'b0110, 4'b0110, 1, 4'b0010, 1, 2, 4'b0010, 1, 2, 0);
        v(1, 4'b0110, 4'b0110, 1, 4'b0100, 1, 1, 4'b0100, 1, 1, 0);
        v(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 2, 4'b0000, 1, 2, 0);
        // Packet lock: stream 2 sends 3 beats while stream 0 waits.
        v(1, 4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 4'b0100, 0, 0, 0);
        v(1, 4'b0101, 4'b0000, 1, 4'b0001, 1, 2, 4'b0100, 1, 2, 0);
        v(1, 4'b0101, 4'b0100, 1, 4'b0100, 1, 0, 4'b0100, 1, 2, 0);
        v(1, 4'b0001, 4'b0000, 1, 4'b0001, 1, 2, 4'b0001, 1, 2, 0);
        v(1, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 4'b0000, 1, 0, 0);
        v(0, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 0);
        // Lock gap: stream 1 idles mid-packet, stream 3 must wait.
        v(1, 4'b1010, 4'b0000, 1, 4'b0010, 0, 0, 4'b0010, 0, 0, 0);
        v(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 4'b0000, 1, 1, 0);
        v(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 3, 4'b0000, 0, 0, 0);
        v(1, 4'b1010, 4'b0010, 1, 4'b0010, 1, 3, 4'b0010, 0, 0, 0);
        v(1, 4'b1000, 4'b0000, 1, 4'b1000, 1, 1, 4'b1000, 1, 1, 0);
        v(0, 4'b0000, 4'b0000, 1, 4'b0000, 1, 3, 4'b0000, 1, 3, 0);
        // Reset in the middle of a locked packet.
        v(1, 4'b0100, 4'b0000, 1, 4'b0100, 0, 0, 4'b0100, 0, 0, 0);
        v(1, 4'b0101, 4'b0000, 1, 4'b0001, 1, 2, 4'b0100, 1, 2, 0);
        v(0, 4'b0101, 4'b0000, 1, 4'b0000, 1, 0, 4'b0000, 1, 2, 0);
        v(0, 4'b0101, 4'b0000, 1, 4'b0000, 0, 0, 4'b0000, 0, 0, 1);
        v(1, 4'b0101, 4'b0000, 1, 4'b0001, 0, 0, 4'b0001, 0, 0, 0);
        v(1, 4'b0101, 4'b0000, 1, 4'b0100, 1, 0, 4'b0001, 1, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].rdy);
            chk($sformatf("vec%0d dut0 ready_in", i), 64'(ri[0]), 64'(vecs[i].ri0));
            chk($sformatf("vec%0d dut0 valid_out", i), 64'(vo[0]), 64'(vecs[i].vo0));
            if (vecs[i].vo0) chk($sformatf("vec%0d dut0 sel_out", i), 64'(sout[0]),
                                 64'(vecs[i].sel0));
            chk($sformatf("vec%0d dut1 ready_in", i), 64'(ri[1]), 64'(vecs[i].ri1));
            chk($sformatf("vec%0d dut1 valid_out", i), 64'(vo[1]), 64'(vecs[i].vo1));
            if (vecs[i].vo1) chk($sformatf("vec%0d dut1 sel_out", i), 64'(sout[1]),
                                 64'(vecs[i].sel1));
            if (vecs[i].zero) begin
                for (int d = 0; d < 2; d++) begin
                    chk($sformatf("vec%0d dut%0d reset outs", i, d),
                        64'({dout[d], lout[d], sout[d]}), 64'd0);
                end
            end
            check_model();
            tick();
        end

        for (int c = 0; c < 3000; c++) begin
            drive(($urandom_range(0, 99) != 0) && (c > 0), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0);
            check_model();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
